mc_control_seq: RTL and testbench
=================================

Name: mc_control_seq

Overview:
Parametrised multicycle control sequencer for the MIPS-subset datapath. It replaces fixed fetch timing with a configurable memory latency. It adds a start/done handshake to the multiply/divide unit, with a timeout. It adds a complete exception path: EPC save, then a vector fetch from memory, for invalid opcode, overflow, divide-by-zero and mult/div timeout. Outputs drive datapath write-enables and mux selects.

Parameters:
MEM_LAT, 2, memory read latency in cycles (≥1). The read address must be held this many cycles before data is valid.
MD_TIMEOUT, 40, maximum cycles spent in MD_WAIT before the timeout exception.
CNT_W, 6, wait-counter width. Must satisfy 2^CNT_W > max(MEM_LAT, MD_TIMEOUT).

Ports:
clk  in  1  clock, rising edge
reset_in  in  1  asynchronous active-high reset
opcode  in  6  IR[31:26]
funct  in  6  IR[5:0]
alu_overflow  in  1  ALU signed overflow, combinational
div_zero  in  1  B register == 0
md_done  in  1  mult/div result valid, 1-cycle pulse
reset_out  out  1  datapath register reset
PC_w, IR_w, MEM_w, A_reg_w, B_reg_w, ALUOut_w, Banco_reg_w, EPC_w, HI_reg_w, LO_reg_w  out  1 each  write enables
Mux_PC  out  2  00 ALU, 01 jump target, 10 A reg, 11 memory byte zero-extended (vector)
Mux_MEM  out  2  00 PC, 01 exception vector address
Mux_ALUSrcA  out  2  00 PC, 01 A
Mux_ALUSrcB  out  2  00 B, 01 const 4, 10 sign-ext imm
Mux_W_RB  out  2  00 rt, 01 rd
Mux_W_DT  out  3  000 ALUOut, 011 HI, 100 LO
Mux_EXC  out  2  vector select: 00 opcode→253, 01 overflow→254, 10 div0→255, 11 timeout→252
ALUOp  out  4  0000 pass, 0001 ADD, 0010 SUB, 0011 AND, 0100 SLT
md_start  out  1  mult/div start pulse
md_sel  out  1  0 MULT, 1 DIV
state_dbg  out  5  current state encoding

Behaviour:
- Moore machine. All outputs decode from the registered state and the latched cause/op registers. Any output not listed for a state is 0.
- reset_in high: state=RESET asynchronously. All outputs 0 except reset_out=1. Counter, cause and md_sel are cleared. The first rising edge with reset_in low moves to FETCH, with reset_out=0. Reset in any state, including mid-MD_WAIT or EXC_WAIT, aborts immediately.
- Counter clears on every state change.
- Encodings: RESET 0, FETCH 1, FETCH_WAIT 2, DECODE 3, EXEC_R 4, EXEC_I 5, WB_R 6, WB_I 7, WB_HL 8, JUMP 9, MD_CHECK 10, MD_START 11, MD_WAIT 12, MD_WB 13, EXC 14, EXC_WAIT 15.
- FETCH: Mux_MEM=00, SrcA=00, SrcB=01, ALUOp=ADD. Next state FETCH_WAIT.
- FETCH_WAIT: holds the FETCH selects for MEM_LAT cycles. In the last cycle (counter==MEM_LAT-1): IR_w=1, PC_w=1, Mux_PC=00. Then DECODE.
- DECODE: A_reg_w=B_reg_w=1. Dispatch on the opcode/funct values on the inputs at the end of the cycle:
  - R add 20, sub 22, and 24, slt 2A → EXEC_R
  - mfhi 10, mflo 12 → WB_HL
  - jr 08 → JUMP
  - mult 18, div 1A → MD_CHECK (md_sel latched: 0 for mult, 1 for div)
  - addi 08, addiu 09, slti 0A → EXEC_I
  - j 02 → JUMP
  - anything else → EXC with cause=00
- EXEC_R: SrcA=01, SrcB=00, ALUOp from funct, ALUOut_w=1. If funct is add/sub and alu_overflow=1 at the end of the cycle → EXC with cause=01. Otherwise → WB_R.
- EXEC_I: SrcA=01, SrcB=10, ALUOp=ADD (addi/addiu) or SLT (slti), ALUOut_w=1. Overflow is checked only for addi. The addiu and slti overflow flags are ignored.
- WB_R: Banco_reg_w=1, Mux_W_RB=01, Mux_W_DT=000. WB_I: same with Mux_W_RB=00. WB_HL: Mux_W_RB=01, Mux_W_DT=011 for mfhi / 100 for mflo. All three → FETCH.
- JUMP: PC_w=1. Mux_PC=01 for j, 10 for jr. → FETCH.
- MD_CHECK: outputs idle. If md_sel=1 and div_zero=1 → EXC with cause=10. Otherwise → MD_START.
- MD_START: md_start=1 for exactly one cycle. → MD_WAIT.
- MD_WAIT: md_sel held. md_done=1 → MD_WB. If the counter reaches MD_TIMEOUT-1 without md_done → EXC with cause=11. If md_done and timeout coincide, md_done wins. md_done in any other state is ignored.
- MD_WB: HI_reg_w=LO_reg_w=1. → FETCH.
- EXC: EPC_w=1, SrcA=00, SrcB=01, ALUOp=SUB (EPC = PC-4). Mux_MEM=01, Mux_EXC=cause. → EXC_WAIT.
- EXC_WAIT: Mux_MEM=01 and Mux_EXC=cause held for MEM_LAT cycles. In the last cycle: PC_w=1, Mux_PC=11. → FETCH.
- Mux_EXC=00 outside the EXC states. The exception path issues no ALU-checked ops, so nested exceptions are impossible.
- Latency at MEM_LAT=2: R-ALU 6 cycles, I-ALU 6, mfhi/j 5. Exception is MEM_LAT+1 cycles after detection.

Test Plan:
- Reset asserted mid-cycle, then released → outputs 0 and reset_out=1 asynchronously. One edge after release: state_dbg=1, reset_out=0.
- add (op 00, funct 20), MEM_LAT=2, no overflow → IR_w and PC_w pulse at cycle 3. Banco_reg_w=1 with Mux_W_RB=01 at cycle 6. state_dbg=1 at cycle 7.
- addi with alu_overflow=1 in EXEC_I → EPC_w=1, Mux_EXC=01, ALUOp=0010. Two cycles later PC_w=1 with Mux_PC=11. WB_I is never entered.
- div with div_zero=1 → MD_CHECK → EXC with Mux_EXC=10. md_start is never asserted.
- mult, md_done pulsed 5 cycles after md_start → HI_reg_w=LO_reg_w=1 in the following cycle. Repeat with md_done never asserted, MD_TIMEOUT=40 → EXC with Mux_EXC=11 after 40 MD_WAIT cycles.
- opcode 3F → EXC with Mux_EXC=00. Separately, reset_in asserted during MD_WAIT → immediate RESET, md_start stays 0, cause cleared.

Source files
------------

// File: rtl/mc_control_seq.sv
// -----------------------------------------------------------------------------
// mc_control_seq
//
// Multicycle control sequencer for a MIPS-subset datapath. A Moore machine
// whose outputs come only from the registered state and the latched
// cause/op/md_sel registers. It provides:
//   - instruction fetch with a configurable memory latency (MEM_LAT),
//   - a start/done handshake to the mult/div unit, with a timeout,
//   - an exception path: EPC save, then a vector fetch from memory.
//
// Mult/div handshake: md_start is a one-cycle pulse issued from MD_START,
// with md_sel held stable for the whole wait. The unit answers with a
// one-cycle md_done pulse. md_done only counts while in MD_WAIT. If md_done
// has not arrived by the last allowed MD_WAIT cycle, the timeout exception
// is taken. md_done in that same cycle still wins.
//
// Ports:
//   clk, reset_in         clock (rising edge), asynchronous active-high reset
//   opcode, funct         IR[31:26], IR[5:0]
//   alu_overflow          ALU signed overflow (combinational)
//   div_zero              B register == 0
//   md_done               mult/div result valid (1-cycle pulse)
//   reset_out             datapath register reset
//   *_w                   datapath register write enables
//   Mux_*                 datapath mux selects
//   ALUOp                 0 pass, 1 ADD, 2 SUB, 3 AND, 4 SLT
//   md_start, md_sel      mult/div start pulse, 0 MULT / 1 DIV
//   state_dbg             current state encoding
// -----------------------------------------------------------------------------
module mc_control_seq #(
  parameter int MEM_LAT    = 2,
  parameter int MD_TIMEOUT = 40,
  parameter int CNT_W      = 6
) (
  input  logic       clk,
  input  logic       reset_in,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       alu_overflow,
  input  logic       div_zero,
  input  logic       md_done,
  output logic       reset_out,
  output logic       PC_w,
  output logic       IR_w,
  output logic       MEM_w,
  output logic       A_reg_w,
  output logic       B_reg_w,
  output logic       ALUOut_w,
  output logic       Banco_reg_w,
  output logic       EPC_w,
  output logic       HI_reg_w,
  output logic       LO_reg_w,
  output logic [1:0] Mux_PC,
  output logic [1:0] Mux_MEM,
  output logic [1:0] Mux_ALUSrcA,
  output logic [1:0] Mux_ALUSrcB,
  output logic [1:0] Mux_W_RB,
  output logic [2:0] Mux_W_DT,
  output logic [1:0] Mux_EXC,
  output logic [3:0] ALUOp,
  output logic       md_start,
  output logic       md_sel,
  output logic [4:0] state_dbg
);

  typedef enum logic [4:0] {
    S_RESET      = 5'd0,
    S_FETCH      = 5'd1,
    S_FETCH_WAIT = 5'd2,
    S_DECODE     = 5'd3,
    S_EXEC_R     = 5'd4,
    S_EXEC_I     = 5'd5,
    S_WB_R       = 5'd6,
    S_WB_I       = 5'd7,
    S_WB_HL      = 5'd8,
    S_JUMP       = 5'd9,
    S_MD_CHECK   = 5'd10,
    S_MD_START   = 5'd11,
    S_MD_WAIT    = 5'd12,
    S_MD_WB      = 5'd13,
    S_EXC        = 5'd14,
    S_EXC_WAIT   = 5'd15
  } state_t;

  // Instruction class latched at DECODE so later states do not depend on IR.
  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_ADD   = 4'd1,
    OP_SUB   = 4'd2,
    OP_AND   = 4'd3,
    OP_SLT   = 4'd4,
    OP_ADDI  = 4'd5,
    OP_ADDIU = 4'd6,
    OP_SLTI  = 4'd7,
    OP_MFHI  = 4'd8,
    OP_MFLO  = 4'd9,
    OP_J     = 4'd10,
    OP_JR    = 4'd11
  } op_t;

  localparam logic [3:0] ALU_PASS = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_SLT  = 4'd4;

  localparam logic [1:0] CAUSE_OPC = 2'b00;
  localparam logic [1:0] CAUSE_OVF = 2'b01;
  localparam logic [1:0] CAUSE_DV0 = 2'b10;
  localparam logic [1:0] CAUSE_TMO = 2'b11;

  localparam logic [CNT_W-1:0] MEM_LAST = CNT_W'(MEM_LAT - 1);
  localparam logic [CNT_W-1:0] MD_LAST  = CNT_W'(MD_TIMEOUT - 1);

  state_t           state_q, state_d;
  op_t              op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       cause_q, cause_d;
  logic             md_sel_q, md_sel_d;

  // Counter restarts on every state change, so in any state it reads the
  // number of cycles already spent there.
  assign cnt_d = (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);

  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      state_q  <= S_RESET;
      op_q     <= OP_NONE;
      cnt_q    <= '0;
      cause_q  <= 2'b00;
      md_sel_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      cause_q  <= cause_d;
      md_sel_q <= md_sel_d;
    end
  end

  assign state_dbg = state_q;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    cause_d     = cause_q;
    md_sel_d    = md_sel_q;
    reset_out   = 1'b0;
    PC_w        = 1'b0;
    IR_w        = 1'b0;
    MEM_w       = 1'b0;
    A_reg_w     = 1'b0;
    B_reg_w     = 1'b0;
    ALUOut_w    = 1'b0;
    Banco_reg_w = 1'b0;
    EPC_w       = 1'b0;
    HI_reg_w    = 1'b0;
    LO_reg_w    = 1'b0;
    Mux_PC      = 2'b00;
    Mux_MEM     = 2'b00;
    Mux_ALUSrcA = 2'b00;
    Mux_ALUSrcB = 2'b00;
    Mux_W_RB    = 2'b00;
    Mux_W_DT    = 3'b000;
    Mux_EXC     = 2'b00;
    ALUOp       = ALU_PASS;
    md_start    = 1'b0;
    md_sel      = 1'b0;

    case (state_q)
      S_RESET: begin
        reset_out = 1'b1;
        state_d   = S_FETCH;
      end

      S_FETCH: begin
        Mux_ALUSrcB = 2'b01;
        ALUOp       = ALU_ADD;
        state_d     = S_FETCH_WAIT;
      end

      // Address and PC+4 selects are held until memory data is valid.
      S_FETCH_WAIT: begin
        Mux_ALUSrcB = 2'b01;
        ALUOp       = ALU_ADD;
        if (cnt_q == MEM_LAST) begin
          IR_w    = 1'b1;
          PC_w    = 1'b1;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        A_reg_w = 1'b1;
        B_reg_w = 1'b1;
        state_d = S_EXC;
        cause_d = CAUSE_OPC;
        case (opcode)
          6'h00: begin
            case (funct)
              6'h20: begin state_d = S_EXEC_R;   op_d = OP_ADD;  end
              6'h22: begin state_d = S_EXEC_R;   op_d = OP_SUB;  end
              6'h24: begin state_d = S_EXEC_R;   op_d = OP_AND;  end
              6'h2A: begin state_d = S_EXEC_R;   op_d = OP_SLT;  end
              6'h10: begin state_d = S_WB_HL;    op_d = OP_MFHI; end
              6'h12: begin state_d = S_WB_HL;    op_d = OP_MFLO; end
              6'h08: begin state_d = S_JUMP;     op_d = OP_JR;   end
              6'h18: begin state_d = S_MD_CHECK; md_sel_d = 1'b0; end
              6'h1A: begin state_d = S_MD_CHECK; md_sel_d = 1'b1; end
              default: ;
            endcase
          end
          6'h08: begin state_d = S_EXEC_I; op_d = OP_ADDI;  end
          6'h09: begin state_d = S_EXEC_I; op_d = OP_ADDIU; end
          6'h0A: begin state_d = S_EXEC_I; op_d = OP_SLTI;  end
          6'h02: begin state_d = S_JUMP;   op_d = OP_J;     end
          default: ;
        endcase
      end

      S_EXEC_R: begin
        Mux_ALUSrcA = 2'b01;
        ALUOut_w    = 1'b1;
        case (op_q)
          OP_ADD:  ALUOp = ALU_ADD;
          OP_SUB:  ALUOp = ALU_SUB;
          OP_AND:  ALUOp = ALU_AND;
          OP_SLT:  ALUOp = ALU_SLT;
          default: ALUOp = ALU_PASS;
        endcase
        if (alu_overflow && (op_q == OP_ADD || op_q == OP_SUB)) begin
          state_d = S_EXC;
          cause_d = CAUSE_OVF;
        end else begin
          state_d = S_WB_R;
        end
      end

      // addiu and slti never trap, whatever the ALU flag says.
      S_EXEC_I: begin
        Mux_ALUSrcA = 2'b01;
        Mux_ALUSrcB = 2'b10;
        ALUOut_w    = 1'b1;
        ALUOp       = (op_q == OP_SLTI) ? ALU_SLT : ALU_ADD;
        if (alu_overflow && op_q == OP_ADDI) begin
          state_d = S_EXC;
          cause_d = CAUSE_OVF;
        end else begin
          state_d = S_WB_I;
        end
      end

      S_WB_R: begin
        Banco_reg_w = 1'b1;
        Mux_W_RB    = 2'b01;
        state_d     = S_FETCH;
      end

      S_WB_I: begin
        Banco_reg_w = 1'b1;
        state_d     = S_FETCH;
      end

      S_WB_HL: begin
        Banco_reg_w = 1'b1;
        Mux_W_RB    = 2'b01;
        Mux_W_DT    = (op_q == OP_MFLO) ? 3'b100 : 3'b011;
        state_d     = S_FETCH;
      end

      S_JUMP: begin
        PC_w    = 1'b1;
        Mux_PC  = (op_q == OP_JR) ? 2'b10 : 2'b01;
        state_d = S_FETCH;
      end

      S_MD_CHECK: begin
        if (md_sel_q && div_zero) begin
          state_d = S_EXC;
          cause_d = CAUSE_DV0;
        end else begin
          state_d = S_MD_START;
        end
      end

      S_MD_START: begin
        md_start = 1'b1;
        md_sel   = md_sel_q;
        state_d  = S_MD_WAIT;
      end

      S_MD_WAIT: begin
        md_sel = md_sel_q;
        if (md_done) begin
          state_d = S_MD_WB;
        end else if (cnt_q == MD_LAST) begin
          state_d = S_EXC;
          cause_d = CAUSE_TMO;
        end
      end

      S_MD_WB: begin
        HI_reg_w = 1'b1;
        LO_reg_w = 1'b1;
        state_d  = S_FETCH;
      end

      // EPC = PC - 4 while the vector address goes out to memory.
      S_EXC: begin
        EPC_w       = 1'b1;
        Mux_ALUSrcB = 2'b01;
        ALUOp       = ALU_SUB;
        Mux_MEM     = 2'b01;
        Mux_EXC     = cause_q;
        state_d     = S_EXC_WAIT;
      end

      S_EXC_WAIT: begin
        Mux_MEM = 2'b01;
        Mux_EXC = cause_q;
        if (cnt_q == MEM_LAST) begin
          PC_w    = 1'b1;
          Mux_PC  = 2'b11;
          state_d = S_FETCH;
        end
      end

      default: state_d = S_RESET;
    endcase
  end

endmodule

// File: tb/tb_mc_control_seq.sv
module tb_mc_control_seq;

  localparam int MEM_LAT    = 2;
  localparam int MD_TIMEOUT = 40;

  localparam logic [3:0] ADD = 4'd1;
  localparam logic [3:0] SUB = 4'd2;
  localparam logic [3:0] AND = 4'd3;
  localparam logic [3:0] SLT = 4'd4;

  localparam logic [12:0] F_PC   = 13'h1000;
  localparam logic [12:0] F_IR   = 13'h0800;
  localparam logic [12:0] F_A    = 13'h0200;
  localparam logic [12:0] F_B    = 13'h0100;
  localparam logic [12:0] F_ALUO = 13'h0080;
  localparam logic [12:0] F_RB   = 13'h0040;
  localparam logic [12:0] F_EPC  = 13'h0020;
  localparam logic [12:0] F_HI   = 13'h0010;
  localparam logic [12:0] F_LO   = 13'h0008;
  localparam logic [12:0] F_MDS  = 13'h0004;
  localparam logic [12:0] F_MSEL = 13'h0002;
  localparam logic [12:0] F_RST  = 13'h0001;

  logic       clk = 1'b0;
  logic       reset_in = 1'b0;
  logic [5:0] opcode = '0, funct = '0;
  logic       alu_overflow = 1'b0, div_zero = 1'b0, md_done = 1'b0;
  logic       reset_out, PC_w, IR_w, MEM_w, A_reg_w, B_reg_w, ALUOut_w;
  logic       Banco_reg_w, EPC_w, HI_reg_w, LO_reg_w, md_start, md_sel;
  logic [1:0] Mux_PC, Mux_MEM, Mux_ALUSrcA, Mux_ALUSrcB, Mux_W_RB, Mux_EXC;
  logic [2:0] Mux_W_DT;
  logic [3:0] ALUOp;
  logic [4:0] state_dbg;

  int n_tests = 0;
  int n_fail  = 0;

  logic [36:0] exp_q[$];
  logic [14:0] in_q[$];
  logic [14:0] cur_in;
  logic [36:0] got, e;
  logic [14:0] nin;

  mc_control_seq #(.MEM_LAT(MEM_LAT), .MD_TIMEOUT(MD_TIMEOUT), .CNT_W(6)) dut (
    .clk(clk), .reset_in(reset_in), .opcode(opcode), .funct(funct),
    .alu_overflow(alu_overflow), .div_zero(div_zero), .md_done(md_done),
    .reset_out(reset_out), .PC_w(PC_w), .IR_w(IR_w), .MEM_w(MEM_w),
    .A_reg_w(A_reg_w), .B_reg_w(B_reg_w), .ALUOut_w(ALUOut_w),
    .Banco_reg_w(Banco_reg_w), .EPC_w(EPC_w), .HI_reg_w(HI_reg_w),
    .LO_reg_w(LO_reg_w), .Mux_PC(Mux_PC), .Mux_MEM(Mux_MEM),
    .Mux_ALUSrcA(Mux_ALUSrcA), .Mux_ALUSrcB(Mux_ALUSrcB), .Mux_W_RB(Mux_W_RB),
    .Mux_W_DT(Mux_W_DT), .Mux_EXC(Mux_EXC), .ALUOp(ALUOp),
    .md_start(md_start), .md_sel(md_sel), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, tests run %0d", n_tests);
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    reset_in = 1'b1;
    @(negedge clk);
    reset_in = 1'b0;
  endtask

  // ---------------- driver ----------------
  task automatic drive_cycle(input logic [14:0] v);
    @(posedge clk);
    #1;
    {opcode, funct, alu_overflow, div_zero, md_done} = v;
    @(negedge clk);
  endtask

  // ---------------- expected-row construction ----------------
  function automatic logic [36:0] ev(input logic [4:0] s, input logic [12:0] fl,
                                     input logic [1:0] mpc, input logic [1:0] mmem,
                                     input logic [1:0] sa, input logic [1:0] sb,
                                     input logic [1:0] wrb, input logic [2:0] wdt,
                                     input logic [1:0] mexc, input logic [3:0] aop);
    return {s, fl, mpc, mmem, sa, sb, wrb, wdt, mexc, aop};
  endfunction

  function automatic logic [36:0] obs();
    return {state_dbg, PC_w, IR_w, MEM_w, A_reg_w, B_reg_w, ALUOut_w, Banco_reg_w,
            EPC_w, HI_reg_w, LO_reg_w, md_start, md_sel, reset_out,
            Mux_PC, Mux_MEM, Mux_ALUSrcA, Mux_ALUSrcB, Mux_W_RB, Mux_W_DT,
            Mux_EXC, ALUOp};
  endfunction

  function automatic logic [36:0] r_reset();
    return ev(5'd0, F_RST, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 4'd0);
  endfunction

  function automatic logic [36:0] r_fetch();
    return ev(5'd1, 13'h0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 3'b000, 2'b00, ADD);
  endfunction

  function automatic logic [36:0] r_mdwait(input logic [12:0] fl);
    return ev(5'd12, fl, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 4'd0);
  endfunction

  task automatic p(input logic [36:0] row);
    exp_q.push_back(row);
    in_q.push_back(cur_in);
  endtask

  task automatic p_fetch();
    p(r_fetch());
    for (int i = 0; i < MEM_LAT - 1; i++)
      p(ev(5'd2, 13'h0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 3'b000, 2'b00, ADD));
    p(ev(5'd2, F_PC | F_IR, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 3'b000, 2'b00, ADD));
    p(ev(5'd3, F_A | F_B, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 4'd0));
  endtask

  task automatic p_exc(input logic [1:0] cause);
    p(ev(5'd14, F_EPC, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 3'b000, cause, SUB));
    for (int i = 0; i < MEM_LAT - 1; i++)
      p(ev(5'd15, 13'h0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, cause, 4'd0));
    p(ev(5'd15, F_PC, 2'b11, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, cause, 4'd0));
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(posedge clk);
    #3 reset_in = 1'b1;
    #1;
    got = obs(); n_tests++;
    if (got !== r_reset()) begin
      n_fail++; $display("FAIL reset_async: got %h exp %h", got, r_reset());
    end
    @(posedge clk);
    @(negedge clk);
    got = obs(); n_tests++;
    if (got !== r_reset()) begin
      n_fail++; $display("FAIL reset_held: got %h exp %h", got, r_reset());
    end
    reset_in = 1'b0;
    drive_cycle(15'h0);
    got = obs(); n_tests++;
    if (got !== r_fetch()) begin
      n_fail++; $display("FAIL reset_release: got %h exp %h", got, r_fetch());
    end
  endtask

  task automatic test_add();
    do_reset();
    cur_in = {6'h00, 6'h20, 1'b0, 1'b0, 1'b1};   // stray md_done is ignored
    p_fetch();
    p(ev(5'd4, F_ALUO, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 3'b000, 2'b00, ADD));
    p(ev(5'd6, F_RB, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 2'b00, 4'd0));
    p(r_fetch());
    for (int c = 1; exp_q.size() > 0; c++) begin
      nin = in_q.pop_front(); e = exp_q.pop_front();
      drive_cycle(nin); got = obs(); n_tests++;
      if (got !== e) begin n_fail++; $display("FAIL add cyc %0d: got %h exp %h", c, got, e); end
    end
  endtask

  task automatic test_addi_ovf();
    do_reset();
    cur_in = {6'h08, 6'h00, 1'b1, 1'b0, 1'b0};
    p_fetch();
    p(ev(5'd5, F_ALUO, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 3'b000, 2'b00, ADD));
    p_exc(2'b01);
    p(r_fetch());
    for (int c = 1; exp_q.size() > 0; c++) begin
      nin = in_q.pop_front(); e = exp_q.pop_front();
      drive_cycle(nin); got = obs(); n_tests++;
      if (got !== e) begin n_fail++; $display("FAIL addi_ovf cyc %0d: got %h exp %h", c, got, e); end
    end
  endtask

  task automatic test_div_zero();
    do_reset();
    cur_in = {6'h00, 6'h1A, 1'b0, 1'b1, 1'b0};
    p_fetch();
    p(ev(5'd10, 13'h0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 4'd0));
    p_exc(2'b10);
    p(r_fetch());
    for (int c = 1; exp_q.size() > 0; c++) begin
      nin = in_q.pop_front(); e = exp_q.pop_front();
      drive_cycle(nin); got = obs(); n_tests++;
      if (got !== e) begin n_fail++; $display("FAIL div_zero cyc %0d: got %h exp %h", c, got, e); end
    end
  endtask

  // done_at: MD_WAIT cycle index (0-based) carrying md_done; < 0 means never.
  task automatic test_mult(input int done_at);
    do_reset();
    cur_in = {6'h00, 6'h18, 1'b0, 1'b0, 1'b0};
    p_fetch();
    p(ev(5'd10, 13'h0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 4'd0));
    p(ev(5'd11, F_MDS, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 4'd0));
    if (done_at >= 0) begin
      for (int i = 0; i < done_at; i++) p(r_mdwait(13'h0));
      cur_in[0] = 1'b1;
      p(r_mdwait(13'h0));
      cur_in[0] = 1'b0;
      p(ev(5'd13, F_HI | F_LO, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 4'd0));
    end else begin
      for (int i = 0; i < MD_TIMEOUT; i++) p(r_mdwait(13'h0));
      p_exc(2'b11);
    end
    p(r_fetch());
    for (int c = 1; exp_q.size() > 0; c++) begin
      nin = in_q.pop_front(); e = exp_q.pop_front();
      drive_cycle(nin); got = obs(); n_tests++;
      if (got !== e) begin
        n_fail++; $display("FAIL mult(done_at=%0d) cyc %0d: got %h exp %h", done_at, c, got, e);
      end
    end
  endtask

  task automatic test_bad_opcode();
    do_reset();
    cur_in = {6'h3F, 6'h20, 1'b0, 1'b0, 1'b0};
    p_fetch();
    p_exc(2'b00);
    p(r_fetch());
    for (int c = 1; exp_q.size() > 0; c++) begin
      nin = in_q.pop_front(); e = exp_q.pop_front();
      drive_cycle(nin); got = obs(); n_tests++;
      if (got !== e) begin n_fail++; $display("FAIL bad_opcode cyc %0d: got %h exp %h", c, got, e); end
    end
  endtask

  // Consecutive instructions with overflow held high: only sub traps.
  task automatic test_back_to_back();
    do_reset();
    cur_in = {6'h09, 6'h00, 1'b1, 1'b0, 1'b0};                // addiu
    p_fetch();
    p(ev(5'd5, F_ALUO, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 3'b000, 2'b00, ADD));
    p(ev(5'd7, F_RB, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 4'd0));
    cur_in = {6'h00, 6'h24, 1'b1, 1'b0, 1'b0};                // and
    p_fetch();
    p(ev(5'd4, F_ALUO, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 3'b000, 2'b00, AND));
    p(ev(5'd6, F_RB, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 2'b00, 4'd0));
    cur_in = {6'h0A, 6'h00, 1'b1, 1'b0, 1'b0};                // slti
    p_fetch();
    p(ev(5'd5, F_ALUO, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 3'b000, 2'b00, SLT));
    p(ev(5'd7, F_RB, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 4'd0));
    cur_in = {6'h00, 6'h2A, 1'b1, 1'b0, 1'b0};                // slt
    p_fetch();
    p(ev(5'd4, F_ALUO, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 3'b000, 2'b00, SLT));
    p(ev(5'd6, F_RB, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 2'b00, 4'd0));
    cur_in = {6'h00, 6'h22, 1'b1, 1'b0, 1'b0};                // sub, traps
    p_fetch();
    p(ev(5'd4, F_ALUO, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 3'b000, 2'b00, SUB));
    p_exc(2'b01);
    p(r_fetch());
    for (int c = 1; exp_q.size() > 0; c++) begin
      nin = in_q.pop_front(); e = exp_q.pop_front();
      drive_cycle(nin); got = obs(); n_tests++;
      if (got !== e) begin n_fail++; $display("FAIL back_to_back cyc %0d: got %h exp %h", c, got, e); end
    end
  endtask

  task automatic test_jumps_hilo();
    do_reset();
    cur_in = {6'h02, 6'h00, 1'b0, 1'b0, 1'b0};                // j
    p_fetch();
    p(ev(5'd9, F_PC, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 4'd0));
    cur_in = {6'h00, 6'h08, 1'b0, 1'b0, 1'b0};                // jr
    p_fetch();
    p(ev(5'd9, F_PC, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 4'd0));
    cur_in = {6'h00, 6'h10, 1'b0, 1'b0, 1'b0};                // mfhi
    p_fetch();
    p(ev(5'd8, F_RB, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 3'b011, 2'b00, 4'd0));
    cur_in = {6'h00, 6'h12, 1'b0, 1'b0, 1'b0};                // mflo
    p_fetch();
    p(ev(5'd8, F_RB, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 3'b100, 2'b00, 4'd0));
    p(r_fetch());
    for (int c = 1; exp_q.size() > 0; c++) begin
      nin = in_q.pop_front(); e = exp_q.pop_front();
      drive_cycle(nin); got = obs(); n_tests++;
      if (got !== e) begin n_fail++; $display("FAIL jumps_hilo cyc %0d: got %h exp %h", c, got, e); end
    end
  endtask

  task automatic test_reset_in_md_wait();
    do_reset();
    cur_in = {6'h00, 6'h1A, 1'b0, 1'b0, 1'b0};                // div, B != 0
    p_fetch();
    p(ev(5'd10, 13'h0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 4'd0));
    p(ev(5'd11, F_MDS | F_MSEL, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 4'd0));
    for (int i = 0; i < 3; i++) p(r_mdwait(F_MSEL));
    for (int c = 1; exp_q.size() > 0; c++) begin
      nin = in_q.pop_front(); e = exp_q.pop_front();
      drive_cycle(nin); got = obs(); n_tests++;
      if (got !== e) begin n_fail++; $display("FAIL div_pre_reset cyc %0d: got %h exp %h", c, got, e); end
    end
    @(posedge clk);
    #3 reset_in = 1'b1;
    #1;
    got = obs(); n_tests++;
    if (got !== r_reset()) begin
      n_fail++; $display("FAIL reset_md_wait: got %h exp %h", got, r_reset());
    end
    @(negedge clk);
    reset_in = 1'b0;
    drive_cycle({6'h00, 6'h1A, 1'b0, 1'b0, 1'b1});
    got = obs(); n_tests++;
    if (got !== r_fetch()) begin
      n_fail++; $display("FAIL reset_md_wait_release: got %h exp %h", got, r_fetch());
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_add();
    test_addi_ovf();
    test_div_zero();
    test_mult(4);                 // md_done 5 cycles after md_start
    test_mult(-1);                // timeout
    test_mult(MD_TIMEOUT - 1);    // md_done coincides with timeout
    test_bad_opcode();
    test_back_to_back();
    test_jumps_hilo();
    test_reset_in_md_wait();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
